// File: rtl/ldst_pkg.sv
// Shared types and helpers for the load/store memory bridge: access size
// encoding, per-request metadata, and the strobe/replicate/extend functions.
package ldst_pkg;

  typedef enum logic [1:0] {
    LDST_SIZE_B = 2'd0,
    LDST_SIZE_H = 2'd1,
    LDST_SIZE_W = 2'd2
  } ldst_size_e;

  // Size is kept as raw bits so the illegal encoding 3 survives into the
  // metadata; it is always flagged as an error before it matters.
  typedef struct packed {
    logic       st;
    logic [1:0] size;
    logic       uns;
    logic [1:0] off;
    logic       err;
  } ldst_meta_t;

  function automatic logic calc_mis(input logic [1:0] size, input logic [1:0] off);
    return ((size == LDST_SIZE_H) && off[0]) ||
           ((size == LDST_SIZE_W) && (off != 2'b00)) ||
           (size == 2'd3);
  endfunction

  function automatic logic [3:0] calc_wstrb(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] strb;
    case (size)
      LDST_SIZE_B: strb = 4'b0001 << off;
      LDST_SIZE_H: strb = 4'b0011 << off;
      LDST_SIZE_W: strb = 4'b1111;
      default:     strb = 4'b0000;
    endcase
    return strb;
  endfunction

  function automatic logic [31:0] calc_wdata(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] rep;
    case (size)
      LDST_SIZE_B: rep = {4{wdata[7:0]}};
      LDST_SIZE_H: rep = {2{wdata[15:0]}};
      default:     rep = wdata;
    endcase
    return rep;
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] off, input logic uns);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {off, 3'b000};
    case (size)
      LDST_SIZE_B: res = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      LDST_SIZE_H: res = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default:     res = sh;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ldst_mem_bridge_if.sv
// Request, response and data-memory bus signals of the load/store bridge.
// slave is the bridge's view; master is the view of the surrounding core/memory.
interface ldst_mem_bridge_if;

  logic        req_vld;
  logic        req_rdy;
  logic [31:0] req_addr;
  logic        req_st;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;

  logic        rsp_vld;
  logic        rsp_rdy;
  logic [31:0] rsp_data;
  logic        rsp_err;

  logic        mem_req_vld;
  logic        mem_req_rdy;
  logic [31:0] mem_req_addr;
  logic        mem_req_we;
  logic [3:0]  mem_req_wstrb;
  logic [31:0] mem_req_wdata;

  logic        mem_rsp_vld;
  logic        mem_rsp_rdy;
  logic [31:0] mem_rsp_data;

  modport slave (
    input  req_vld, req_addr, req_st, req_size, req_unsigned, req_wdata,
    output req_rdy,
    output rsp_vld, rsp_data, rsp_err,
    input  rsp_rdy,
    output mem_req_vld, mem_req_addr, mem_req_we, mem_req_wstrb, mem_req_wdata,
    input  mem_req_rdy,
    input  mem_rsp_vld, mem_rsp_data,
    output mem_rsp_rdy
  );

  modport master (
    output req_vld, req_addr, req_st, req_size, req_unsigned, req_wdata,
    input  req_rdy,
    input  rsp_vld, rsp_data, rsp_err,
    output rsp_rdy,
    input  mem_req_vld, mem_req_addr, mem_req_we, mem_req_wstrb, mem_req_wdata,
    output mem_req_rdy,
    output mem_rsp_vld, mem_rsp_data,
    input  mem_rsp_rdy
  );

endinterface

// File: rtl/ldst_meta_fifo.sv
// Synchronous FIFO holding per-request metadata between acceptance and
// response. Push while full is accepted when a pop happens in the same cycle.
module ldst_meta_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign dout  = mem_q[rd_ptr_q];

  // Pointer, occupancy and storage update for accepted push/pop.
  always_comb begin
    push_ok  = push & (~full | pop);
    pop_ok   = pop & ~empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_ok) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  // FIFO state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ldst_mem_bridge.sv
// Load/store bridge: passes aligned requests straight onto the data-memory
// bus, flags misaligned ones locally, and returns in-order responses through
// a single registered output slot with lane extraction and sign extension.
module ldst_mem_bridge
  import ldst_pkg::*;
#(
  parameter int OUTST = 2
) (
  input logic clk,
  input logic rst,
  ldst_mem_bridge_if.slave bus
);

  localparam int MW = $bits(ldst_meta_t);

  logic          mis;
  logic          push;
  logic          pop;
  logic          meta_full;
  logic          meta_empty;
  logic          slot_free;
  logic          mem_hs;
  logic          err_pop;
  ldst_meta_t    push_meta;
  ldst_meta_t    head;
  logic [MW-1:0] head_bits;

  logic          rsp_vld_q, rsp_vld_d;
  logic [31:0]   rsp_data_q, rsp_data_d;
  logic          rsp_err_q, rsp_err_d;

  ldst_meta_fifo #(
    .DEPTH (OUTST),
    .WIDTH (MW)
  ) u_meta_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_meta),
    .pop   (pop),
    .dout  (head_bits),
    .full  (meta_full),
    .empty (meta_empty)
  );

  assign head = ldst_meta_t'(head_bits);

  // Request side: alignment check, same-cycle memory request, metadata push.
  always_comb begin
    mis               = calc_mis(bus.req_size, bus.req_addr[1:0]);
    bus.req_rdy       = ~meta_full & (mis | bus.mem_req_rdy);
    bus.mem_req_vld   = bus.req_vld & ~meta_full & ~mis;
    bus.mem_req_addr  = {bus.req_addr[31:2], 2'b00};
    bus.mem_req_we    = bus.req_st;
    bus.mem_req_wstrb = bus.req_st ? calc_wstrb(bus.req_size, bus.req_addr[1:0]) : 4'b0000;
    bus.mem_req_wdata = calc_wdata(bus.req_size, bus.req_wdata);
    push              = bus.req_vld & ~meta_full & (mis | bus.mem_req_rdy);
    push_meta         = '{st:   bus.req_st,
                          size: bus.req_size,
                          uns:  bus.req_unsigned,
                          off:  bus.req_addr[1:0],
                          err:  mis};
  end

  // Response side: pop the head on a memory beat or immediately for an error,
  // and load the output slot. Ready stays high while nothing is outstanding
  // since a memory beat with no outstanding request is illegal anyway.
  always_comb begin
    slot_free       = ~rsp_vld_q | bus.rsp_rdy;
    bus.mem_rsp_rdy = slot_free & (meta_empty | ~head.err);
    mem_hs          = bus.mem_rsp_vld & bus.mem_rsp_rdy & ~meta_empty;
    err_pop         = slot_free & ~meta_empty & head.err;
    pop             = mem_hs | err_pop;

    rsp_vld_d  = rsp_vld_q & ~bus.rsp_rdy;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    if (pop) begin
      rsp_vld_d = 1'b1;
      rsp_err_d = head.err;
      if (head.err || head.st) begin
        rsp_data_d = 32'h0;
      end else begin
        rsp_data_d = extend_load(bus.mem_rsp_data, head.size, head.off, head.uns);
      end
    end
  end

  // Output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_vld_q  <= 1'b0;
      rsp_data_q <= 32'h0;
      rsp_err_q  <= 1'b0;
    end else begin
      rsp_vld_q  <= rsp_vld_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign bus.rsp_vld  = rsp_vld_q;
  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_err  = rsp_err_q;

  a_no_orphan_mem_rsp: assert property (@(posedge clk) disable iff (rst)
    !(bus.mem_rsp_vld && meta_empty));

endmodule

// File: tb/tb_ldst_mem_bridge.sv
// Bench for ldst_mem_bridge: table of load/store vectors plus hand-written
// sequences for latency, ordering, back-pressure and reset flush. A behavioural
// memory with configurable latency serves the bus; a scoreboard queue holds
// expected responses pushed at request acceptance.
module tb_ldst_mem_bridge;

  logic clk;
  logic rst;

  ldst_mem_bridge_if bus ();

  ldst_mem_bridge #(.OUTST(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  typedef struct {
    logic [31:0] data;
    int          due;
  } mrsp_t;

  typedef struct {
    logic [31:0] addr;
    logic        st;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [3:0]  ewstrb;
    logic [31:0] emwdata;
    logic [31:0] edata;
    logic        eerr;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  mrsp_t       mq[$];
  int          cyc = 0;
  int          mem_lat = 1;
  logic [31:0] mem_arr [logic [31:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model: samples handshakes at negedge, updates just after posedge.
  initial begin : mem_model
    logic        f_req, f_rsp, f_rst, we;
    logic [31:0] a, wd, rd;
    logic [3:0]  strb;
    bus.mem_rsp_vld  = 1'b0;
    bus.mem_rsp_data = 32'h0;
    forever begin
      @(negedge clk);
      f_rst = rst;
      f_req = bus.mem_req_vld && bus.mem_req_rdy;
      f_rsp = bus.mem_rsp_vld && bus.mem_rsp_rdy;
      a     = bus.mem_req_addr;
      we    = bus.mem_req_we;
      wd    = bus.mem_req_wdata;
      strb  = bus.mem_req_wstrb;
      rd    = mem_arr.exists(a) ? mem_arr[a] : 32'h0;
      @(posedge clk);
      #1;
      cyc++;
      if (f_rst) begin
        mq.delete();
      end else begin
        if (f_rsp) void'(mq.pop_front());
        if (f_req) begin
          if (we) begin
            for (int b = 0; b < 4; b++) if (strb[b]) rd[8*b +: 8] = wd[8*b +: 8];
            mem_arr[a] = rd;
          end
          mq.push_back('{data: rd, due: cyc + mem_lat - 1});
        end
      end
      bus.mem_rsp_vld  = 1'b0;
      bus.mem_rsp_data = 32'h0;
      if (mq.size() > 0) begin
        bus.mem_rsp_data = mq[0].data;
        if (mq[0].due <= cyc) bus.mem_rsp_vld = 1'b1;
      end
    end
  end

  // Scoreboard: compare every response handshake against the queue head.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.rsp_vld && bus.rsp_rdy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp actual=%h required=none", bus.rsp_data);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_data", bus.rsp_data, e.data);
          chk("rsp_err", {31'h0, bus.rsp_err}, {31'h0, e.err});
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Entered and left just after a rising edge; returns wait cycles before accept.
  task automatic send(input logic [31:0] addr, input logic st, input logic [1:0] size,
                      input logic uns, input logic [31:0] wdata, input logic [3:0] ewstrb,
                      input logic [31:0] emwdata, input logic [31:0] edata, input logic eerr,
                      output int stalls);
    bit done;
    stalls           = 0;
    done             = 0;
    bus.req_vld      = 1'b1;
    bus.req_addr     = addr;
    bus.req_st       = st;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_wdata    = wdata;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.req_rdy) begin
        done = 1;
        if (eerr) begin
          chk("mem_req_vld_err", {31'h0, bus.mem_req_vld}, 32'h0);
        end else begin
          chk("mem_req_vld", {31'h0, bus.mem_req_vld}, 32'h1);
          chk("mem_req_addr", bus.mem_req_addr, {addr[31:2], 2'b00});
          chk("mem_req_we", {31'h0, bus.mem_req_we}, {31'h0, st});
          chk("mem_req_wstrb", {28'h0, bus.mem_req_wstrb}, {28'h0, ewstrb});
          if (st) chk("mem_req_wdata", bus.mem_req_wdata, emwdata);
        end
        exp_q.push_back('{data: edata, err: eerr});
      end else begin
        stalls++;
      end
      @(posedge clk);
      #1;
    end
    if (!done) chk("req_accept_timeout", 32'h0, 32'h1);
    bus.req_vld = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_left", exp_q.size(), 32'h0);
  endtask

  vec_t vecs[14];

  initial begin : main
    int st_cnt;
    vecs[0]  = '{32'h100, 1'b0, 2'd2, 1'b0, 32'h0,        4'b0000, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[1]  = '{32'h107, 1'b0, 2'd0, 1'b0, 32'h0,        4'b0000, 32'h0,        32'hFFFFFF80, 1'b0};
    vecs[2]  = '{32'h107, 1'b0, 2'd0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h00000080, 1'b0};
    vecs[3]  = '{32'h10A, 1'b0, 2'd1, 1'b0, 32'h0,        4'b0000, 32'h0,        32'hFFFF8001, 1'b0};
    vecs[4]  = '{32'h10A, 1'b0, 2'd1, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h00008001, 1'b0};
    vecs[5]  = '{32'h10D, 1'b0, 2'd0, 1'b0, 32'h0,        4'b0000, 32'h0,        32'h0000007F, 1'b0};
    vecs[6]  = '{32'h201, 1'b1, 2'd0, 1'b0, 32'h5A,       4'b0010, 32'h5A5A5A5A, 32'h0,        1'b0};
    vecs[7]  = '{32'h202, 1'b1, 2'd1, 1'b0, 32'h1234ABCD, 4'b1100, 32'hABCDABCD, 32'h0,        1'b0};
    vecs[8]  = '{32'h204, 1'b1, 2'd2, 1'b0, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D, 32'h0,        1'b0};
    vecs[9]  = '{32'h109, 1'b0, 2'd1, 1'b0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1};
    vecs[10] = '{32'h106, 1'b0, 2'd2, 1'b0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1};
    vecs[11] = '{32'h10C, 1'b0, 2'd3, 1'b0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1};
    vecs[12] = '{32'h204, 1'b0, 2'd2, 1'b0, 32'h0,        4'b0000, 32'h0,        32'hCAFEF00D, 1'b0};
    vecs[13] = '{32'h201, 1'b0, 2'd0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0000005A, 1'b0};

    mem_arr[32'h000] = 32'h11111111;
    mem_arr[32'h004] = 32'h22222222;
    mem_arr[32'h100] = 32'hDEADBEEF;
    mem_arr[32'h104] = 32'h80FFFFFF;
    mem_arr[32'h108] = 32'h80010000;
    mem_arr[32'h10C] = 32'h00007F00;
    mem_arr[32'h200] = 32'h0;
    mem_arr[32'h204] = 32'h0;

    rst              = 1'b1;
    bus.req_vld      = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_st       = 1'b0;
    bus.req_size     = 2'd2;
    bus.req_unsigned = 1'b0;
    bus.req_wdata    = 32'h0;
    bus.rsp_rdy      = 1'b1;
    bus.mem_req_rdy  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    chk("rst_rsp_vld", {31'h0, bus.rsp_vld}, 32'h0);
    chk("rst_rsp_data", bus.rsp_data, 32'h0);
    chk("rst_rsp_err", {31'h0, bus.rsp_err}, 32'h0);
    chk("rst_req_rdy", {31'h0, bus.req_rdy}, 32'h1);
    chk("rst_mem_req_vld", {31'h0, bus.mem_req_vld}, 32'h0);
    chk("rst_mem_rsp_rdy", {31'h0, bus.mem_rsp_rdy}, 32'h1);
    @(posedge clk);
    #1;

    // Load latency: memory answers one cycle after the request, response one cycle later.
    send(32'h100, 1'b0, 2'd2, 1'b0, 32'h0, 4'b0000, 32'h0, 32'hDEADBEEF, 1'b0, st_cnt);
    @(negedge clk);
    chk("lat_rsp_vld_early", {31'h0, bus.rsp_vld}, 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("lat_rsp_vld", {31'h0, bus.rsp_vld}, 32'h1);
    @(posedge clk);
    #1;
    drain();

    // Vector table, issued back to back.
    foreach (vecs[i]) begin
      send(vecs[i].addr, vecs[i].st, vecs[i].size, vecs[i].uns, vecs[i].wdata,
           vecs[i].ewstrb, vecs[i].emwdata, vecs[i].edata, vecs[i].eerr, st_cnt);
    end
    drain();

    // In-order with an error in the middle; third request waits for a FIFO slot.
    mem_lat = 2;
    send(32'h000, 1'b0, 2'd2, 1'b0, 32'h0, 4'b0000, 32'h0, 32'h11111111, 1'b0, st_cnt);
    send(32'h003, 1'b0, 2'd1, 1'b0, 32'h0, 4'b0000, 32'h0, 32'h0,        1'b1, st_cnt);
    send(32'h004, 1'b0, 2'd2, 1'b0, 32'h0, 4'b0000, 32'h0, 32'h22222222, 1'b0, st_cnt);
    chk("full_stall_cycles", st_cnt, 32'd1);
    mem_lat = 1;
    drain();

    // Memory back-pressure: misaligned goes through anyway, aligned waits.
    bus.mem_req_rdy = 1'b0;
    send(32'h101, 1'b0, 2'd1, 1'b0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, st_cnt);
    chk("mis_no_mem_stall", st_cnt, 32'd0);
    fork
      send(32'h104, 1'b0, 2'd2, 1'b0, 32'h0, 4'b0000, 32'h0, 32'h80FFFFFF, 1'b0, st_cnt);
      begin
        repeat (2) @(posedge clk);
        #1;
        bus.mem_req_rdy = 1'b1;
      end
    join
    chk("mem_rdy_stall_cycles", st_cnt, 32'd2);
    drain();

    // Output stalled with two in flight, then released.
    bus.rsp_rdy = 1'b0;
    send(32'h100, 1'b0, 2'd2, 1'b0, 32'h0, 4'b0000, 32'h0, 32'hDEADBEEF, 1'b0, st_cnt);
    send(32'h104, 1'b0, 2'd2, 1'b0, 32'h0, 4'b0000, 32'h0, 32'h80FFFFFF, 1'b0, st_cnt);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_rsp_vld", {31'h0, bus.rsp_vld}, 32'h1);
      chk("hold_rsp_data", bus.rsp_data, 32'hDEADBEEF);
      chk("hold_mem_rsp_rdy", {31'h0, bus.mem_rsp_rdy}, 32'h0);
      @(posedge clk);
      #1;
    end
    bus.rsp_rdy = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("drain_b2b_vld", {31'h0, bus.rsp_vld}, 32'h1);
    chk("drain_b2b_data", bus.rsp_data, 32'h80FFFFFF);
    @(posedge clk);
    #1;
    drain();

    // Reset with two requests outstanding.
    mem_lat = 3;
    send(32'h100, 1'b0, 2'd2, 1'b0, 32'h0, 4'b0000, 32'h0, 32'hDEADBEEF, 1'b0, st_cnt);
    send(32'h104, 1'b0, 2'd2, 1'b0, 32'h0, 4'b0000, 32'h0, 32'h80FFFFFF, 1'b0, st_cnt);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    mem_lat = 1;
    @(negedge clk);
    chk("flush_rsp_vld", {31'h0, bus.rsp_vld}, 32'h0);
    chk("flush_req_rdy", {31'h0, bus.req_rdy}, 32'h1);
    chk("flush_mem_rsp_rdy", {31'h0, bus.mem_rsp_rdy}, 32'h1);
    @(posedge clk);
    #1;
    send(32'h108, 1'b0, 2'd2, 1'b0, 32'h0, 4'b0000, 32'h0, 32'h80010000, 1'b0, st_cnt);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
